// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared state type, op encodings and decoder mapping for the HI/LO mult/div unit
package muldiv_pkg;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} md_state_t;
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;
  localparam logic [3:0] ALU_MULT = 4'b1000;
  localparam logic [3:0] ALU_DIV  = 4'b1001;
  // EX uses this to turn the decoder's alucontrol into the sequencer op code
  function automatic logic [1:0] alu_to_op(input logic [3:0] alucontrol, input logic is_unsigned);
    return {alucontrol == ALU_DIV, is_unsigned};
  endfunction
endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: issue/result bundle between the EX stage and the mult/div sequencer
interface muldiv_if #(parameter int WIDTH = 32);
  logic             start;
  logic             flush;
  logic [1:0]       op;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic             busy;
  logic             hilo_we;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master (output start, flush, op, srca, srcb, input busy, hilo_we, hi, lo);
  modport slave  (input start, flush, op, srca, srcb, output busy, hilo_we, hi, lo);
endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one radix-2 iteration, shift-add multiply or restoring divide
module muldiv_step #(parameter int WIDTH = 32) (
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] pr_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] pr_o,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   r_sh;
  logic [WIDTH-1:0] diff;
  logic             ge;
  // mult: conditional add then shift {carry,P,Q} right; div: shift {R,Q} left and try to subtract
  always_comb begin
    sum  = {1'b0, pr_i} + (q_i[0] ? {1'b0, b_i} : '0);
    r_sh = {pr_i, q_i[WIDTH-1]};
    ge   = r_sh >= {1'b0, b_i};
    diff = r_sh[WIDTH-1:0] - b_i;
    pr_o = is_div_i ? (ge ? diff : r_sh[WIDTH-1:0]) : sum[WIDTH:1];
    q_o  = is_div_i ? {q_i[WIDTH-2:0], ge} : {sum[0], q_i[WIDTH-1:1]};
  end
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative MULT/MULTU/DIV/DIVU sequencer driving the HI/LO registers
module muldiv_seq import muldiv_pkg::*; #(parameter int WIDTH = 32) (
  input logic      clk,
  input logic      reset_n,
  muldiv_if.slave  bus
);
  localparam int CNTW = $clog2(WIDTH) + 1;
  md_state_t          state_q, state_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   p_q, p_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   mag_a, mag_b, pr_n, q_n;
  logic [2*WIDTH-1:0] prod_neg;
  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i(is_div_q),
    .pr_i    (p_q),
    .q_i     (q_q),
    .b_i     (b_q),
    .pr_o    (pr_n),
    .q_o     (q_n)
  );
  assign mag_a       = (!bus.op[0] && bus.srca[WIDTH-1]) ? -bus.srca : bus.srca;
  assign mag_b       = (!bus.op[0] && bus.srcb[WIDTH-1]) ? -bus.srcb : bus.srcb;
  assign prod_neg    = -{p_q, q_q};
  assign bus.busy    = state_q != S_IDLE;
  assign bus.hilo_we = (state_q == S_DONE) && !bus.flush;
  assign bus.hi      = bus.hilo_we ? p_q : hi_q;
  assign bus.lo      = bus.hilo_we ? q_q : lo_q;
  // next state and datapath: latch magnitudes, iterate, sign-fix, commit; flush aborts any busy state
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    a_d      = a_q;
    b_d      = b_q;
    p_d      = p_q;
    q_d      = q_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      S_IDLE: if (bus.start && !bus.flush) begin
        state_d  = S_CALC;
        cnt_d    = CNTW'(WIDTH);
        is_div_d = bus.op[1];
        sign_a_d = !bus.op[0] && bus.srca[WIDTH-1];
        sign_b_d = !bus.op[0] && bus.srcb[WIDTH-1];
        a_d      = bus.srca;
        p_d      = '0;
        q_d      = bus.op[1] ? mag_a : mag_b;
        b_d      = bus.op[1] ? mag_b : mag_a;
      end
      S_CALC: begin
        p_d     = pr_n;
        q_d     = q_n;
        cnt_d   = cnt_q - CNTW'(1);
        state_d = (cnt_q == CNTW'(1)) ? S_FIX : S_CALC;
      end
      S_FIX: begin
        state_d    = S_DONE;
        {p_d, q_d} = !is_div_q ? ((sign_a_q ^ sign_b_q) ? prod_neg : {p_q, q_q})
                   : (b_q == '0) ? {a_q, {WIDTH{1'b1}}}
                   : {sign_a_q ? -p_q : p_q, (sign_a_q ^ sign_b_q) ? -q_q : q_q};
      end
      S_DONE: begin
        state_d = S_IDLE;
        hi_d    = bus.flush ? hi_q : p_q;
        lo_d    = bus.flush ? lo_q : q_q;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_q != S_IDLE && bus.flush) state_d = S_IDLE;
  end
  // state and datapath registers, cleared immediately by reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      p_q      <= '0;
      q_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      a_q      <= a_d;
      b_q      <= b_d;
      p_q      <= p_d;
      q_q      <= q_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end
endmodule
